hermes_tx_slice: RTL and testbench
==================================

HERMES_TX_SLICE -- requirements
Module: hermes_tx_slice

Interface
REQ-001 Parameter FLIT_SIZE, default 32: Hermes flit width in bits.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk_i  in  1  single clock.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 rx_i  in  1  flit valid from DMNI noc_tx_o.
REQ-006 eop_i  in  1  last flit of packet, qualified by rx_i.
REQ-007 credit_o  out  1  ready to DMNI noc_credit_i.
REQ-008 data_i  in  FLIT_SIZE  flit from DMNI.
REQ-009 tx_o  out  1  flit valid to router local port.
REQ-010 eop_o  out  1  last-flit marker, qualified by tx_o.
REQ-011 credit_i  in  1  router ready.
REQ-012 data_o  out  FLIT_SIZE  flit to router.
REQ-013 clr_i  in  1  synchronous clear of pkt_cnt_o and len_err_o.
REQ-014 pkt_cnt_o  out  32  packets forwarded, wrapping.
REQ-015 len_err_o  out  1  sticky packet-length error.
REQ-016 busy_o  out  1  high while a packet is partially forwarded or any flit is held.

Function
REQ-017 Transfer rule, both sides: a flit moves in a cycle where valid and ready are both high; no other cycle moves a flit.
REQ-018 Storage is a main output register plus one skid register; data_o, eop_o and tx_o come directly from the main register.
REQ-019 credit_o SHALL be the registered inverse of skid-full, with no combinational path from credit_i.
REQ-020 Input flit, main register empty or draining this cycle, skid empty: flit loads main register.
REQ-021 Input flit, main register full and not draining: flit loads skid.
REQ-022 Main register drains while skid is full: skid moves to main and skid empties.
REQ-023 Latency: a flit accepted in cycle N with the slice empty SHALL be on data_o with tx_o high in cycle N+1.
REQ-024 Throughput: one flit per cycle sustained while credit_i stays high.
REQ-025 Flit order and eop marking SHALL be preserved exactly; no flit is dropped or duplicated.
REQ-026 Checker FSM advances only on output-side transfers; states HEADER, SIZE, PAYLOAD.
REQ-027 HEADER, flit without eop: go to SIZE; flit with eop: set len_err, stay in HEADER.
REQ-028 SIZE, flit with eop: set len_err if the size value is nonzero, go to HEADER.
REQ-029 SIZE, flit without eop: load remaining with data (32 bits, zero-extended); if the size value is 0, set len_err; go to PAYLOAD.
REQ-030 PAYLOAD, each flit: decrement remaining, saturating at 0.
REQ-031 PAYLOAD, flit with eop: set len_err if remaining is not 1; go to HEADER.
REQ-032 PAYLOAD, flit without eop: set len_err if remaining is 1 or less; stay in PAYLOAD.
REQ-033 pkt_cnt_o increments by 1 on every output transfer with eop, wrapping from FFFFFFFF to 0.
REQ-034 clr_i clears pkt_cnt_o and len_err_o; in the same cycle it overrides an increment or an error set, leaving result 0.
REQ-035 busy_o = main valid OR skid valid OR FSM not in HEADER.

Reset
REQ-036 Reset asserted: tx_o=0, eop_o=0, data_o=0, credit_o=1, pkt_cnt_o=0, len_err_o=0, busy_o=0, FSM=HEADER, remaining=0.
REQ-037 Reset asserted mid-packet: all held flits are discarded immediately (asynchronous).
REQ-038 After reset release: the next flit is treated as a header.

Verification
REQ-039 Basic packet: flits 0x0101, 0x2, 0xA, 0xB (eop on last), credit_i=1 -> same flits appear one cycle later; pkt_cnt_o=1; len_err_o=0.
REQ-040 Backpressure: credit_i=0 while 3 flits are offered -> 2 accepted, credit_o=0 from the cycle after the second acceptance; credit_i=1 -> flits out in order, credit_o back to 1.
REQ-041 Short packet: size=3 with eop on payload flit 2 -> len_err_o=1 and pkt_cnt_o=1.
REQ-042 Long packet: size=1 with 2 payload flits, eop on the last -> len_err_o=1, FSM returns to HEADER.
REQ-043 Counter wrap and clear: preload 0xFFFFFFFF, then send one packet -> pkt_cnt_o=0; assert clr_i in the same cycle as an eop transfer -> pkt_cnt_o=0 and len_err_o=0.
REQ-044 Reset mid-packet: assert rst_ni low after the SIZE flit -> outputs at reset values; a new 3-flit packet of size 1 -> len_err_o=0.

Source files
------------

// File: rtl/hermes_tx_slice.sv
// Hermes local-port TX slice: two-entry skid buffer between DMNI and router,
// plus a packet-length checker and forwarded-packet counter on the output side.
module hermes_tx_slice #(
    parameter int FLIT_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 eop_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 tx_o,
    output logic                 eop_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 clr_i,
    output logic [31:0]          pkt_cnt_o,
    output logic                 len_err_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } chk_state_t;

    logic                 main_valid;
    logic                 main_eop;
    logic [FLIT_SIZE-1:0] main_data;
    logic                 skid_valid;
    logic                 skid_eop;
    logic [FLIT_SIZE-1:0] skid_data;
    logic                 skid_next;
    logic                 credit_q;
    logic                 in_xfer;
    logic                 out_xfer;

    chk_state_t  state_q;
    chk_state_t  state_d;
    logic [31:0] remaining_q;
    logic [31:0] remaining_d;
    logic [31:0] size_val;
    logic        err_set;
    logic [31:0] pkt_cnt_q;
    logic        len_err_q;

    assign in_xfer  = rx_i & credit_q;
    assign out_xfer = main_valid & credit_i;

    // The skid fills only when a flit arrives while main is stuck; it empties
    // on the cycle main drains. credit is registered from this next value.
    assign skid_next = skid_valid ? ~out_xfer : (in_xfer & main_valid & ~out_xfer);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid <= 1'b0;
            main_eop   <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_eop   <= 1'b0;
            skid_data  <= '0;
            credit_q   <= 1'b1;
        end else begin
            if (skid_valid) begin
                if (out_xfer) begin
                    main_data <= skid_data;
                    main_eop  <= skid_eop;
                end
            end else if (in_xfer) begin
                if (!main_valid || out_xfer) begin
                    main_valid <= 1'b1;
                    main_data  <= data_i;
                    main_eop   <= eop_i;
                end else begin
                    skid_data <= data_i;
                    skid_eop  <= eop_i;
                end
            end else if (out_xfer) begin
                main_valid <= 1'b0;
                main_eop   <= 1'b0;
            end
            skid_valid <= skid_next;
            credit_q   <= ~skid_next;
        end
    end

    // The size field is the low 32 bits of the flit, zero-extended when narrower.
    generate
        if (FLIT_SIZE >= 32) begin : g_size_wide
            assign size_val = main_data[31:0];
        end else begin : g_size_narrow
            assign size_val = {{(32-FLIT_SIZE){1'b0}}, main_data};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HEADER;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        err_set     = 1'b0;
        if (out_xfer) begin
            case (state_q)
                HEADER: begin
                    if (main_eop) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = SIZE;
                    end
                end
                SIZE: begin
                    if (main_eop) begin
                        err_set = (size_val != 32'd0);
                        state_d = HEADER;
                    end else begin
                        remaining_d = size_val;
                        err_set     = (size_val == 32'd0);
                        state_d     = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining_d = (remaining_q == 32'd0) ? 32'd0 : remaining_q - 32'd1;
                    if (main_eop) begin
                        err_set = (remaining_q != 32'd1);
                        state_d = HEADER;
                    end else begin
                        err_set = (remaining_q <= 32'd1);
                    end
                end
                default: state_d = HEADER;
            endcase
        end
    end

    // clr wins over a same-cycle increment or error set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else if (clr_i) begin
            pkt_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (out_xfer && main_eop) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (err_set) begin
                len_err_q <= 1'b1;
            end
        end
    end

    assign credit_o  = credit_q;
    assign tx_o      = main_valid;
    assign eop_o     = main_eop;
    assign data_o    = main_data;
    assign pkt_cnt_o = pkt_cnt_q;
    assign len_err_o = len_err_q;
    assign busy_o    = main_valid | skid_valid | (state_q != HEADER);

endmodule

// File: tb/tb_hermes_tx_slice.sv
// Self-checking bench for hermes_tx_slice: directed scenarios plus random
// traffic, checked against a packet-level scoreboard model.
module tb_hermes_tx_slice;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_i;
    logic        eop_i;
    logic        credit_o;
    logic [31:0] data_i;
    logic        tx_o;
    logic        eop_o;
    logic        credit_i;
    logic [31:0] data_o;
    logic        clr_i;
    logic [31:0] pkt_cnt_o;
    logic        len_err_o;
    logic        busy_o;

    typedef struct packed {
        logic        eop;
        logic [31:0] data;
    } flit_t;

    int          vectors = 0;
    int          miscompares = 0;
    flit_t       exp_q[$];
    logic [31:0] tx_pkt[$];
    logic [31:0] mdl_cnt = '0;
    logic        mdl_err = 1'b0;
    int          pkt_len = 0;
    logic [31:0] pkt_size = '0;
    int          cred_pct = 100;
    int          gap_pct = 0;
    logic [31:0] basic_flits[4];

    hermes_tx_slice #(.FLIT_SIZE(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_i     (rx_i),
        .eop_i    (eop_i),
        .credit_o (credit_o),
        .data_i   (data_i),
        .tx_o     (tx_o),
        .eop_o    (eop_o),
        .credit_i (credit_i),
        .data_o   (data_o),
        .clr_i    (clr_i),
        .pkt_cnt_o(pkt_cnt_o),
        .len_err_o(len_err_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic pick(int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Inputs change on the falling edge so they are stable at the next rising edge.
    task automatic drive(input logic rx, input logic eop, input logic [31:0] data,
                         input logic cred, input logic clr);
        @(negedge clk_i);
        rx_i     = rx;
        eop_i    = eop;
        data_i   = data;
        credit_i = cred;
        clr_i    = clr;
    endtask

    // A packet is legal when it is header+size(0), or header+size+N payload with size==N.
    task automatic scoreboard();
        flit_t f;
        logic  e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni) begin
                if (tx_o && credit_i) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL flit_order: got eop=%0b data=%h, expected no flit", eop_o, data_o);
                    end else begin
                        f = exp_q.pop_front();
                        if ({eop_o, data_o} !== f) begin
                            miscompares++;
                            $display("[TB] FAIL flit_order: got eop=%0b data=%h, expected eop=%0b data=%h",
                                     eop_o, data_o, f.eop, f.data);
                        end
                        pkt_len++;
                        if (pkt_len == 2) pkt_size = f.data;
                        if (f.eop) begin
                            if (pkt_len == 1) e = 1'b1;
                            else if (pkt_len == 2) e = (pkt_size != 32'd0);
                            else e = (pkt_size != 32'(pkt_len - 2));
                            if (e) mdl_err = 1'b1;
                            mdl_cnt = mdl_cnt + 32'd1;
                            pkt_len = 0;
                        end
                    end
                end
                if (rx_i && credit_o) exp_q.push_back({eop_i, data_i});
                if (clr_i) begin
                    mdl_cnt = '0;
                    mdl_err = 1'b0;
                end
            end
        end
    endtask

    task automatic send_pkt();
        logic acc;
        for (int i = 0; i < tx_pkt.size(); i++) begin
            while (pick(gap_pct)) drive(1'b0, 1'b0, 32'd0, pick(cred_pct), 1'b0);
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                drive(1'b1, i == tx_pkt.size() - 1, tx_pkt[i], pick(cred_pct), 1'b0);
                acc = credit_o;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL send_timeout: flit %0d credit_o=%0b, required 1", i, credit_o);
            end
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            #3;
            done = (exp_q.size() == 0) && !tx_o;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d flits still expected, tx_o=%0b", exp_q.size(), tx_o);
        end
    endtask

    task automatic check_counters(input string name);
        vectors++;
        if (pkt_cnt_o !== mdl_cnt) begin
            miscompares++;
            $display("[TB] FAIL %s_pkt_cnt: got %h, expected %h", name, pkt_cnt_o, mdl_cnt);
        end
        vectors++;
        if (len_err_o !== mdl_err) begin
            miscompares++;
            $display("[TB] FAIL %s_len_err: got %0b, expected %0b", name, len_err_o, mdl_err);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({tx_o, eop_o, credit_o, len_err_o, busy_o} !== 5'b00100) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got tx/eop/credit/err/busy=%b, expected 00100",
                     {tx_o, eop_o, credit_o, len_err_o, busy_o});
        end
        vectors++;
        if (data_o !== 32'd0 || pkt_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got data=%h cnt=%h, expected 0 and 0", data_o, pkt_cnt_o);
        end
    endtask

    task automatic test_basic();
        basic_flits = '{32'h0101, 32'h2, 32'hA, 32'hB};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 3, basic_flits[i], 1'b1, 1'b0);
            vectors++;
            if (credit_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL basic_credit: got %0b, expected 1", credit_o);
            end
            if (i > 0) begin
                vectors++;
                if (tx_o !== 1'b1 || data_o !== basic_flits[i-1] || eop_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL basic_latency: got tx=%0b data=%h eop=%0b, expected 1 %h 0",
                             tx_o, data_o, eop_o, basic_flits[i-1]);
                end
            end
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        vectors++;
        if (tx_o !== 1'b1 || data_o !== 32'hB || eop_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_last: got tx=%0b data=%h eop=%0b, expected 1 0000000b 1", tx_o, data_o, eop_o);
        end
        drain();
        check_counters("basic");
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 32'h0202, 1'b0, 1'b0);
        vectors++;
        if (credit_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_first_credit: got %0b, expected 1", credit_o);
        end
        drive(1'b1, 1'b0, 32'd1, 1'b0, 1'b0);
        vectors++;
        if (credit_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_second_credit: got %0b, expected 1", credit_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'hC, i == 2, 1'b0);
            vectors++;
            if (credit_o !== 1'b0 || tx_o !== 1'b1 || data_o !== 32'h0202) begin
                miscompares++;
                $display("[TB] FAIL bp_stall: got credit=%0b tx=%0b data=%h, expected 0 1 00000202",
                         credit_o, tx_o, data_o);
            end
        end
        drive(1'b1, 1'b1, 32'hC, 1'b1, 1'b0);
        vectors++;
        if (credit_o !== 1'b1 || data_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL bp_resume: got credit=%0b data=%h, expected 1 00000001", credit_o, data_o);
        end
        drain();
        vectors++;
        if (credit_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_credit_back: got %0b, expected 1", credit_o);
        end
        check_counters("bp");
    endtask

    task automatic test_length_errors();
        tx_pkt = '{32'h0303, 32'd3, 32'h11, 32'h12};
        send_pkt();
        drain();
        vectors++;
        if (len_err_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL short_len_err: got %0b, expected 1", len_err_o);
        end
        check_counters("short");
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_counters("clear");
        tx_pkt = '{32'h0404, 32'd1, 32'h21, 32'h22};
        send_pkt();
        drain();
        vectors++;
        if (len_err_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL long_pkt: got err=%0b busy=%0b, expected 1 0", len_err_o, busy_o);
        end
        check_counters("long");
    endtask

    task automatic test_wrap_and_clear();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        mdl_cnt = 32'hFFFF_FFFF;
        vectors++;
        if (pkt_cnt_o !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_preload: got %h, expected ffffffff", pkt_cnt_o);
        end
        tx_pkt = '{32'h0505, 32'd1, 32'h31};
        send_pkt();
        drain();
        check_counters("wrap");
        tx_pkt = '{32'h0606, 32'd0};
        send_pkt();
        drain();
        check_counters("pre_clear");
        drive(1'b1, 1'b1, 32'h0707, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        vectors++;
        if (tx_o !== 1'b1 || eop_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clr_eop_setup: got tx=%0b eop=%0b, expected 1 1", tx_o, eop_o);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        vectors++;
        if (pkt_cnt_o !== 32'd0 || len_err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_override: got cnt=%h err=%0b, expected 0 0", pkt_cnt_o, len_err_o);
        end
        check_counters("clr_override");
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 1'b0, 32'h0808, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h41, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        vectors++;
        if (busy_o !== 1'b1 || tx_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_pkt_busy: got busy=%0b tx=%0b, expected 1 1", busy_o, tx_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        exp_q.delete();
        pkt_len = 0;
        mdl_cnt = '0;
        mdl_err = 1'b0;
        #2;
        vectors++;
        if ({tx_o, eop_o, credit_o, len_err_o, busy_o} !== 5'b00100 || data_o !== 32'd0 || pkt_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got flags=%b data=%h cnt=%h, expected 00100 0 0",
                     {tx_o, eop_o, credit_o, len_err_o, busy_o}, data_o, pkt_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tx_pkt = '{32'h0909, 32'd1, 32'h51};
        send_pkt();
        drain();
        vectors++;
        if (len_err_o !== 1'b0 || pkt_cnt_o !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_pkt: got err=%0b cnt=%h, expected 0 1", len_err_o, pkt_cnt_o);
        end
    endtask

    task automatic test_random_traffic();
        int n;
        cred_pct = 60;
        gap_pct = 30;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(6, 1);
            tx_pkt.delete();
            tx_pkt.push_back($urandom);
            if (n >= 2) tx_pkt.push_back(pick(75) ? 32'(n - 2) : 32'($urandom_range(5)));
            for (int k = 2; k < n; k++) tx_pkt.push_back($urandom);
            send_pkt();
        end
        cred_pct = 100;
        gap_pct = 0;
        drain();
        check_counters("random");
    endtask

    initial begin
        rst_ni   = 1'b0;
        rx_i     = 1'b0;
        eop_i    = 1'b0;
        data_i   = '0;
        credit_i = 1'b0;
        clr_i    = 1'b0;
        fork
            scoreboard();
        join_none
        test_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        test_basic();
        test_backpressure();
        test_length_errors();
        test_wrap_and_clear();
        test_reset_mid_packet();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
